// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage.
// Consumes the EX/MEM register and performs loads and stores against a variable-latency
// data memory over a req/ack handshake. It stalls upstream while an access is outstanding,
// aborts hung accesses with a watchdog, and writes the MEM/WB register every cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   EX_MEM[105:0]       {PC+4, MemtoReg, RegWrite, MemWrite, MemRead, rd, alu/addr, store data}
//   dmem_req/we/addr/wdata  request side of the data memory handshake
//   dmem_ack/rdata      completion and load data from the data memory
//   MEM_Stall           freezes PC, IF_ID, ID_EX and EX_MEM
//   MEM_RegWrite, MEM_WriteRegister, MEM_RegWriteData  forwarding back to EX
//   MEM_WB[37:0]        {RegWrite, rd, writeback data}
//   mem_fault           sticky watchdog-abort flag, cleared only by reset
module mem_stage #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [105:0] EX_MEM,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [31:0]  dmem_addr,
   output logic [31:0]  dmem_wdata,
   input  logic         dmem_ack,
   input  logic [31:0]  dmem_rdata,
   output logic         MEM_Stall,
   output logic         MEM_RegWrite,
   output logic [4:0]   MEM_WriteRegister,
   output logic [31:0]  MEM_RegWriteData,
   output logic [37:0]  MEM_WB,
   output logic         mem_fault
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   // EX/MEM field decode
   logic [31:0] store_data;
   logic [31:0] alu_result;
   logic [4:0]  write_reg;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic [1:0]  mem_to_reg;
   logic [31:0] pc_plus4;
   logic        mem_op;

   assign store_data = EX_MEM[31:0];
   assign alu_result = EX_MEM[63:32];
   assign write_reg  = EX_MEM[68:64];
   assign mem_read   = EX_MEM[69];
   assign mem_write  = EX_MEM[70];
   assign reg_write  = EX_MEM[71];
   assign mem_to_reg = EX_MEM[73:72];
   assign pc_plus4   = EX_MEM[105:74];
   assign mem_op     = mem_read | mem_write;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fault_q, fault_d;
   logic [37:0]       mem_wb_q, mem_wb_d;
   logic              abort;
   logic [31:0]       wb_data;

   // Watchdog FSM: counts WAIT cycles without ack; the IDLE request cycle is not counted.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fault_d  = fault_q;
      abort    = 1'b0;
      dmem_req = 1'b0;
      case (state_q)
         StIdle: begin
            dmem_req = mem_op;
            if (mem_op && !dmem_ack) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            if (dmem_ack) begin
               // Ack wins over a simultaneous timeout.
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               fault_d = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            dmem_req = ~abort;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign dmem_we    = mem_write;
   assign dmem_addr  = alu_result;
   assign dmem_wdata = store_data;
   assign MEM_Stall  = mem_op & ~dmem_ack & ~abort;

   always_comb begin
      wb_data = alu_result;
      case (mem_to_reg)
         2'b01:   wb_data = dmem_rdata;
         2'b10:   wb_data = pc_plus4;
         default: wb_data = alu_result;
      endcase
   end

   // Load data is not forwarded; ID stalls on load-use instead.
   assign MEM_RegWriteData  = (mem_to_reg == 2'b10) ? pc_plus4 : alu_result;
   assign MEM_RegWrite      = reg_write;
   assign MEM_WriteRegister = write_reg;

   // Stall and abort cycles both retire a bubble.
   assign mem_wb_d = (mem_op && !dmem_ack) ? 38'd0 : {reg_write, write_reg, wb_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         fault_q  <= 1'b0;
         mem_wb_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fault_q  <= fault_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   assign MEM_WB    = mem_wb_q;
   assign mem_fault = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic         clk;
   logic         rst_n;
   logic [105:0] ex_mem;
   logic         dmem_req;
   logic         dmem_we;
   logic [31:0]  dmem_addr;
   logic [31:0]  dmem_wdata;
   logic         dmem_ack;
   logic [31:0]  dmem_rdata;
   logic         mem_stall;
   logic         mem_regwrite;
   logic [4:0]   mem_writereg;
   logic [31:0]  mem_regwritedata;
   logic [37:0]  mem_wb;
   logic         mem_fault;

   int n_pass  = 0;
   int n_total = 0;

   mem_stage #(
      .TIMEOUT (16),
      .CNT_W   (5)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .EX_MEM            (ex_mem),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_ack          (dmem_ack),
      .dmem_rdata        (dmem_rdata),
      .MEM_Stall         (mem_stall),
      .MEM_RegWrite      (mem_regwrite),
      .MEM_WriteRegister (mem_writereg),
      .MEM_RegWriteData  (mem_regwritedata),
      .MEM_WB            (mem_wb),
      .mem_fault         (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [105:0] mk(input logic [31:0] pc4, input logic [1:0] mtr,
                                       input logic rw, input logic mw, input logic mr,
                                       input logic [4:0] rd, input logic [31:0] alu,
                                       input logic [31:0] sd);
      return {pc4, mtr, rw, mw, mr, rd, alu, sd};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      rst_n      = 1'b0;
      ex_mem     = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;

      // Reset state
      #12;
      chk("rst_mem_wb", 64'(mem_wb), 64'd0);
      chk("rst_fault", 64'(mem_fault), 64'd0);
      chk("rst_req", 64'(dmem_req), 64'd0);
      chk("rst_stall", 64'(mem_stall), 64'd0);
      chk("rst_we", 64'(dmem_we), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU op
      ex_mem = mk(32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
      @(negedge clk);
      chk("alu_stall", 64'(mem_stall), 64'd0);
      chk("alu_req", 64'(dmem_req), 64'd0);
      chk("alu_fwd_data", 64'(mem_regwritedata), 64'h1234);
      chk("alu_fwd_rw", 64'(mem_regwrite), 64'd1);
      chk("alu_fwd_rd", 64'(mem_writereg), 64'd5);
      @(posedge clk); #1;
      chk("alu_mem_wb", 64'(mem_wb), 64'({1'b1, 5'd5, 32'h0000_1234}));

      // Zero-wait load
      ex_mem     = mk(32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd8, 32'h40, 32'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ld0_req", 64'(dmem_req), 64'd1);
      chk("ld0_we", 64'(dmem_we), 64'd0);
      chk("ld0_stall", 64'(mem_stall), 64'd0);
      chk("ld0_addr", 64'(dmem_addr), 64'h40);
      chk("ld0_fwd", 64'(mem_regwritedata), 64'h40);
      @(posedge clk); #1;
      chk("ld0_mem_wb", 64'(mem_wb), 64'({1'b1, 5'd8, 32'hDEAD_BEEF}));

      // Back-to-back zero-wait load, MemRead and MemWrite both set: store wins
      ex_mem     = mk(32'd0, 2'b00, 1'b0, 1'b1, 1'b1, 5'd0, 32'h44, 32'h1111_2222);
      dmem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("both_we", 64'(dmem_we), 64'd1);
      chk("both_stall", 64'(mem_stall), 64'd0);
      @(posedge clk); #1;
      chk("both_mem_wb", 64'(mem_wb), 64'({1'b0, 5'd0, 32'h44}));

      // Store acked three cycles after request
      ex_mem   = mk(32'd0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 32'h80, 32'hA5A5_A5A5);
      dmem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("st_stall", 64'(mem_stall), 64'd1);
         chk("st_req", 64'(dmem_req), 64'd1);
         chk("st_we", 64'(dmem_we), 64'd1);
         chk("st_addr", 64'(dmem_addr), 64'h80);
         chk("st_wdata", 64'(dmem_wdata), 64'hA5A5_A5A5);
         @(posedge clk); #1;
         chk("st_bubble", 64'(mem_wb), 64'd0);
      end
      dmem_ack = 1'b1;
      @(negedge clk);
      chk("st_ack_stall", 64'(mem_stall), 64'd0);
      chk("st_ack_req", 64'(dmem_req), 64'd1);
      @(posedge clk); #1;
      chk("st_wb37", 64'(mem_wb[37]), 64'd0);
      chk("st_mem_wb", 64'(mem_wb), 64'({1'b0, 5'd0, 32'h80}));

      // jal writeback; stray ack with no request must be ignored
      ex_mem = mk(32'h0040_0008, 2'b10, 1'b1, 1'b0, 1'b0, 5'd31, 32'h999, 32'd0);
      @(negedge clk);
      chk("jal_req", 64'(dmem_req), 64'd0);
      chk("jal_fwd", 64'(mem_regwritedata), 64'h0040_0008);
      @(posedge clk); #1;
      chk("jal_mem_wb", 64'(mem_wb), 64'({1'b1, 5'd31, 32'h0040_0008}));
      dmem_ack = 1'b0;

      // Ack arrives on the timeout cycle: completes, no fault
      ex_mem = mk(32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd10, 32'h200, 32'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("late_stall", 64'(mem_stall), 64'd1);
         @(posedge clk); #1;
      end
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("late_req", 64'(dmem_req), 64'd1);
      chk("late_stall_end", 64'(mem_stall), 64'd0);
      @(posedge clk); #1;
      chk("late_mem_wb", 64'(mem_wb), 64'({1'b1, 5'd10, 32'h1234_5678}));
      chk("late_fault", 64'(mem_fault), 64'd0);
      dmem_ack = 1'b0;

      // Load never acked: abort on the 16th WAIT cycle
      ex_mem = mk(32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd9, 32'h100, 32'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("to_stall", 64'(mem_stall), 64'd1);
         chk("to_req", 64'(dmem_req), 64'd1);
         @(posedge clk); #1;
         chk("to_bubble", 64'(mem_wb), 64'd0);
         chk("to_nofault", 64'(mem_fault), 64'd0);
      end
      @(negedge clk);
      chk("abort_stall", 64'(mem_stall), 64'd0);
      chk("abort_req", 64'(dmem_req), 64'd0);
      @(posedge clk); #1;
      chk("abort_fault", 64'(mem_fault), 64'd1);
      chk("abort_mem_wb", 64'(mem_wb), 64'd0);
      ex_mem = mk(32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3, 32'h77, 32'd0);
      @(negedge clk);
      chk("post_abort_stall", 64'(mem_stall), 64'd0);
      @(posedge clk); #1;
      chk("post_abort_mem_wb", 64'(mem_wb), 64'({1'b1, 5'd3, 32'h77}));
      chk("fault_sticky", 64'(mem_fault), 64'd1);

      // Reset pulsed mid-WAIT
      ex_mem = mk(32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd4, 32'h300, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_req", 64'(dmem_req), 64'd1);
      rst_n  = 1'b0;
      ex_mem = '0;
      #1;
      chk("arst_mem_wb", 64'(mem_wb), 64'd0);
      chk("arst_fault", 64'(mem_fault), 64'd0);
      chk("arst_req", 64'(dmem_req), 64'd0);
      chk("arst_stall", 64'(mem_stall), 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // In WAIT the request would stay high even with EX_MEM cleared.
      chk("rel_idle_req", 64'(dmem_req), 64'd0);
      ex_mem = mk(32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd6, 32'hCAFE, 32'd0);
      @(negedge clk);
      chk("rel_stall", 64'(mem_stall), 64'd0);
      @(posedge clk); #1;
      chk("rel_mem_wb", 64'(mem_wb), 64'({1'b1, 5'd6, 32'h0000_CAFE}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
